pc_sequencer: RTL and testbench

Parametrised program-counter sequencer: it holds the PC register and applies sequential increment, relative branches, call and return, and halt/fault control. Branch offsets come from either a sign-extended immediate or a run-time-writable offset LUT. A bounded return stack supports one level of subroutine nesting per entry. The block sits between the instruction decoder (control inputs) and instruction ROM (`prog_ctr` output).

---
 rtl/pc_seq_pkg.sv | 35 +++
 rtl/pc_offset_lut.sv | 37 +++
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg -- shared types and constants for the program-counter sequencer.
//   pc_state_t         : sequencer FSM state encoding.
//   DEFAULT_LUT        : reset contents of the branch-offset LUT (12-bit form).
//   default_lut_entry(): sign-extended default for any LUT index (0 if none).
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_FAULT = 2'd3
   } pc_state_t;

   localparam int DEFAULT_LUT_N = 16;

   // Signed offsets: -5, +20, -1, zeros, -130, +13, -120.
   localparam logic signed [11:0] DEFAULT_LUT [DEFAULT_LUT_N] = '{
      12'hFFB, 12'h014, 12'hFFF, 12'h000,
      12'h000, 12'h000, 12'h000, 12'h000,
      12'h000, 12'h000, 12'h000, 12'h000,
      12'h000, 12'hF7E, 12'h00D, 12'hF88
   };

   // Returned as a signed int so callers can size it to any offset width
   // without losing the sign.
   function automatic int default_lut_entry(input int idx);
      int result;
      result = 0;
      if (idx >= 0 && idx < DEFAULT_LUT_N) begin
         result = int'(DEFAULT_LUT[idx[3:0]]);
      end
      return result;
   endfunction

endpackage

// File: rtl/pc_offset_lut.sv
// pc_offset_lut -- branch-offset register file.
//   clk_i, rst_i  : clock, asynchronous active-high reset (reloads defaults).
//   we_i, waddr_i, wdata_i : single write port, effective after the edge.
//   raddr_i, rdata_o       : combinational read port (sees the pre-write value
//                            in the same cycle as a write to that index).
module pc_offset_lut
   import pc_seq_pkg::*;
#(
   parameter int D     = 12,
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [D-1:0]     wdata_i,
   input  logic [IDX_W-1:0] raddr_i,
   output logic [D-1:0]     rdata_o
);

   logic [D-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // Entries beyond the default table load as zero.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= D'(default_lut_entry(i));
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter with relative branch, call/return and
// halt/fault control.
//   Clk, Reset        : clock, asynchronous active-high reset.
//   start             : (re)start execution at PC 0 from IDLE/DONE/FAULT.
//   branch_en, call, ret, halt : RUN-state controls (priority halt > ret >
//                       call > branch_en > increment).
//   immOrLUT, pc_ctrl_input : offset source (LUT index or signed immediate).
//   lut_we, lut_waddr, lut_wdata : offset LUT write port (any state).
//   prog_ctr, sp      : registered PC and return-stack occupancy.
//   running, done, fault : registered state flags.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int D           = 12,
   parameter int LUT_DEPTH   = 16,
   parameter int IDX_W       = $clog2(LUT_DEPTH),
   parameter int STACK_DEPTH = 4
) (
   input  logic                             Clk,
   input  logic                             Reset,
   input  logic                             start,
   input  logic                             branch_en,
   input  logic                             call,
   input  logic                             ret,
   input  logic                             halt,
   input  logic                             immOrLUT,
   input  logic [IDX_W-1:0]                 pc_ctrl_input,
   input  logic                             lut_we,
   input  logic [IDX_W-1:0]                 lut_waddr,
   input  logic [D-1:0]                     lut_wdata,
   output logic [D-1:0]                     prog_ctr,
   output logic                             running,
   output logic                             done,
   output logic                             fault,
   output logic [$clog2(STACK_DEPTH+1)-1:0] sp
);

   localparam int SP_W   = $clog2(STACK_DEPTH+1);
   localparam int STK_IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   pc_state_t        state_q;
   logic [D-1:0]     pc_q;
   logic [SP_W-1:0]  sp_q;
   logic             running_q, done_q, fault_q;
   logic [D-1:0]     stack_q [STACK_DEPTH];

   logic [D-1:0]      lut_rdata;
   logic [D-1:0]      offset_d;
   logic [D-1:0]      pc_inc_d;
   logic [D-1:0]      pc_br_d;
   logic              stack_full, stack_empty;
   logic [STK_IW-1:0] push_idx, pop_idx;
   logic              push_d;

   pc_offset_lut #(
      .D     (D),
      .DEPTH (LUT_DEPTH),
      .IDX_W (IDX_W)
   ) u_lut (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .we_i    (lut_we),
      .waddr_i (lut_waddr),
      .wdata_i (lut_wdata),
      .raddr_i (pc_ctrl_input),
      .rdata_o (lut_rdata)
   );

   // Size cast of a signed operand sign-extends the immediate.
   assign offset_d    = immOrLUT ? lut_rdata : D'($signed(pc_ctrl_input));
   assign pc_inc_d    = pc_q + D'(1);
   assign pc_br_d     = pc_q + offset_d;
   assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp_q == '0);
   assign push_idx    = STK_IW'(sp_q);
   assign pop_idx     = STK_IW'(sp_q - SP_W'(1));

   // A call pushes only when it wins the priority and the stack has room.
   assign push_d = (state_q == ST_RUN) && !halt && !ret && call && !stack_full;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         sp_q      <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
               if (start) begin
                  state_q   <= ST_RUN;
                  pc_q      <= '0;
                  sp_q      <= '0;
                  running_q <= 1'b1;
                  done_q    <= 1'b0;
                  fault_q   <= 1'b0;
               end
            end
            ST_RUN: begin
               if (halt) begin
                  state_q   <= ST_DONE;
                  running_q <= 1'b0;
                  done_q    <= 1'b1;
               end else if (ret) begin
                  if (stack_empty) begin
                     state_q   <= ST_FAULT;
                     running_q <= 1'b0;
                     fault_q   <= 1'b1;
                  end else begin
                     pc_q <= stack_q[pop_idx];
                     sp_q <= sp_q - SP_W'(1);
                  end
               end else if (call) begin
                  if (stack_full) begin
                     state_q   <= ST_FAULT;
                     running_q <= 1'b0;
                     fault_q   <= 1'b1;
                  end else begin
                     pc_q <= pc_br_d;
                     sp_q <= sp_q + SP_W'(1);
                  end
               end else if (branch_en) begin
                  pc_q <= pc_br_d;
               end else begin
                  pc_q <= pc_inc_d;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               running_q <= 1'b0;
               done_q    <= 1'b0;
               fault_q   <= 1'b0;
            end
         endcase
      end
   end

   // Stack storage needs no reset: sp alone says which entries are live.
   always_ff @(posedge Clk) begin
      if (push_d) begin
         stack_q[push_idx] <= pc_inc_d;
      end
   end

   assign prog_ctr = pc_q;
   assign sp       = sp_q;
   assign running  = running_q;
   assign done     = done_q;
   assign fault    = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   localparam int W = 18;  // {pc[11:0], sp[2:0], running, done, fault}

   localparam logic [4:0] C_NONE  = 5'b00000;
   localparam logic [4:0] C_START = 5'b10000;
   localparam logic [4:0] C_HALT  = 5'b01000;
   localparam logic [4:0] C_RET   = 5'b00100;
   localparam logic [4:0] C_CALL  = 5'b00010;
   localparam logic [4:0] C_BR    = 5'b00001;

   localparam logic [2:0] F_NONE = 3'b000;
   localparam logic [2:0] F_RUN  = 3'b100;
   localparam logic [2:0] F_DONE = 3'b010;
   localparam logic [2:0] F_FLT  = 3'b001;

   logic        Clk, Reset;
   logic        start, branch_en, call, ret, halt, immOrLUT;
   logic [3:0]  pc_ctrl_input;
   logic        lut_we;
   logic [3:0]  lut_waddr;
   logic [11:0] lut_wdata;
   logic [11:0] prog_ctr;
   logic        running, done, fault;
   logic [2:0]  sp;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks = 0;
   int           errors = 0;

   logic        w_pend = 1'b0;
   logic [3:0]  w_idx  = '0;
   logic [11:0] w_data = '0;

   pc_sequencer dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .start         (start),
      .branch_en     (branch_en),
      .call          (call),
      .ret           (ret),
      .halt          (halt),
      .immOrLUT      (immOrLUT),
      .pc_ctrl_input (pc_ctrl_input),
      .lut_we        (lut_we),
      .lut_waddr     (lut_waddr),
      .lut_wdata     (lut_wdata),
      .prog_ctr      (prog_ctr),
      .running       (running),
      .done          (done),
      .fault         (fault),
      .sp            (sp)
   );

   // ---------------- clock / reset ----------------
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      {start, halt, ret, call, branch_en} = C_NONE;
      immOrLUT      = 1'b0;
      pc_ctrl_input = '0;
      lut_we        = 1'b0;
      lut_waddr     = '0;
      lut_wdata     = '0;
   endtask

   task automatic lut_wr(input logic [3:0] idx, input logic [11:0] data);
      w_pend = 1'b1;
      w_idx  = idx;
      w_data = data;
   endtask

   // Drive one cycle of controls and queue the state expected after the edge.
   task automatic step(input logic [4:0] ctl, input logic iol,
                       input logic [3:0] idx, input logic [11:0] e_pc,
                       input logic [2:0] e_sp, input logic [2:0] e_fl,
                       input string nm);
      @(negedge Clk);
      {start, halt, ret, call, branch_en} = ctl;
      immOrLUT      = iol;
      pc_ctrl_input = idx;
      lut_we        = w_pend;
      lut_waddr     = w_idx;
      lut_wdata     = w_data;
      w_pend        = 1'b0;
      exp_q.push_back({e_pc, e_sp, e_fl});
      name_q.push_back(nm);
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin : monitor
      logic [W-1:0] exp_v, act_v;
      string        nm;
      forever begin
         @(posedge Clk or posedge Reset);
         #1;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {prog_ctr, sp, running, done, fault};
            checks++;
            if (act_v !== exp_v) begin
               errors++;
               $display("FAIL %s: got pc=%h sp=%0d run/done/fault=%b, expected pc=%h sp=%0d run/done/fault=%b",
                        nm, act_v[17:6], act_v[5:3], act_v[2:0],
                        exp_v[17:6], exp_v[5:3], exp_v[2:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stimulus
      Reset = 1'b1;
      clear_inputs();
      step(C_NONE, 0, 0, 12'h000, 0, F_NONE, "reset");
      @(posedge Clk); #2; Reset = 1'b0;

      // free run
      step(C_START, 0, 0, 12'h000, 0, F_RUN, "start");
      for (int i = 1; i <= 10; i++) step(C_NONE, 0, 0, 12'(i), 0, F_RUN, "count");

      // immediate branches and wrap
      step(C_BR, 0, 4'b1110, 12'd8,   0, F_RUN, "imm_neg");
      step(C_BR, 0, 4'b1000, 12'd0,   0, F_RUN, "imm_to0");
      step(C_BR, 0, 4'b1111, 12'hFFF, 0, F_RUN, "imm_wrap");
      step(C_NONE, 0, 0,     12'h000, 0, F_RUN, "inc_wrap");

      // LUT branches and same-cycle rewrite
      lut_wr(4'd5, 12'd199);
      step(C_NONE, 0, 0,  12'd1,   0, F_RUN, "nop_w5");
      step(C_BR, 1, 4'd5,  12'd200, 0, F_RUN, "lut5");
      step(C_BR, 1, 4'd13, 12'd70,  0, F_RUN, "lut13");
      lut_wr(4'd13, 12'd3);
      step(C_BR, 1, 4'd13, 12'hFC4, 0, F_RUN, "lut13_same_cyc");
      step(C_BR, 1, 4'd13, 12'hFC7, 0, F_RUN, "lut13_new");
      lut_wr(4'd6, 12'd61);
      step(C_NONE, 0, 0,  12'hFC8, 0, F_RUN, "nop_w6");
      step(C_BR, 1, 4'd6,  12'd5,   0, F_RUN, "lut6");

      // call / return nesting
      step(C_CALL, 1, 4'd1, 12'd25, 1, F_RUN, "call_lut");
      for (int i = 26; i <= 30; i++) step(C_NONE, 0, 0, 12'(i), 1, F_RUN, "count2");
      step(C_CALL, 0, 4'b0010, 12'd32, 2, F_RUN, "call_imm");
      step(C_RET, 0, 0, 12'd31, 1, F_RUN, "ret1");
      step(C_RET, 0, 0, 12'd6,  0, F_RUN, "ret2");

      // underflow fault, hold, restart
      step(C_RET, 0, 0, 12'd6, 0, F_FLT, "ret_underflow");
      step(C_BR | C_CALL, 0, 4'd1, 12'd6, 0, F_FLT, "fault_hold");
      step(C_START, 0, 0, 12'd0, 0, F_RUN, "restart_flt");

      // overflow fault
      for (int i = 1; i <= 4; i++) step(C_CALL, 0, 4'b0001, 12'(i), 3'(i), F_RUN, "call_fill");
      step(C_CALL, 0, 4'b0001, 12'd4, 4, F_FLT, "call_overflow");
      step(C_START, 0, 0, 12'd0, 0, F_RUN, "restart_ovf");

      // halt priority
      step(C_CALL, 0, 4'b0001, 12'd1, 1, F_RUN, "call_one");
      step(C_HALT | C_CALL, 0, 4'b0001, 12'd1, 1, F_DONE, "halt_call");
      step(C_CALL | C_BR, 0, 4'b0001, 12'd1, 1, F_DONE, "done_hold");
      step(C_START, 0, 0, 12'd0, 0, F_RUN, "restart_done");
      step(C_START, 0, 0, 12'd1, 0, F_RUN, "start_in_run");
      lut_wr(4'd0, 12'd7);
      step(C_NONE, 0, 0, 12'd2, 0, F_RUN, "nop_w0");

      // asynchronous reset mid-cycle
      @(negedge Clk);
      clear_inputs();
      #2;
      exp_q.push_back('0);
      name_q.push_back("async_reset");
      Reset = 1'b1;
      @(posedge Clk); #2; Reset = 1'b0;

      // LUT defaults reloaded
      step(C_START, 0, 0, 12'd0, 0, F_RUN, "start_after_rst");
      step(C_NONE, 0, 0, 12'd1, 0, F_RUN, "run_after_rst");
      step(C_BR, 1, 4'd0,  12'hFFC, 0, F_RUN, "lut0_default");
      step(C_BR, 1, 4'd13, 12'hF7A, 0, F_RUN, "lut13_default");
      step(C_HALT, 0, 0, 12'hF7A, 0, F_DONE, "halt");

      @(negedge Clk);
      clear_inputs();
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge Clk);
      #3;
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
